// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle datapath: sequences
// fetch/decode/execute/memory/writeback and drives all enables.
module multicycle_main_control #(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               illegal_op,
  output logic               instr_done,
  output logic [CNT_W-1:0]   retired,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    WB_LOAD   = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    WB_R      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    EXEC_I    = 4'd10,
    WB_I      = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Outputs are held low for the whole of reset, even though
  // state_q already reads FETCH.
  always_comb begin
    state_d     = FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    instr_done  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b10;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          state_d = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          ALUOp   = 2'b10;
          case (opcode)
            OP_LW, OP_SW: state_d = MEM_ADDR;
            OP_R:         state_d = EXEC_R;
            OP_BEQ:       state_d = BRANCH;
            OP_J:         state_d = JUMP;
            OP_ADDI:      state_d = EXEC_I;
            default: begin
              illegal_op = 1'b1;
              state_d    = FETCH;
            end
          endcase
        end
        MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b10;
          state_d = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
        end
        MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          state_d = mem_ready ? WB_LOAD : MEM_READ;
        end
        WB_LOAD: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        MEM_WRITE: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
          state_d    = mem_ready ? FETCH : MEM_WRITE;
        end
        EXEC_R: begin
          ALUSrcA = 1'b1;
          state_d = WB_R;
        end
        WB_R: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b10;
          state_d = WB_I;
        end
        WB_I: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign retired_d = retired_q + CNT_W'(instr_done);
  assign retired   = retired_q;
  assign state     = STATE_W'(state_q);

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle datapath. Sits directly upstream of the ALU control unit.
- Decodes the 6-bit opcode held in the instruction register.
- Sequences fetch/decode/execute/memory/writeback and drives every datapath enable.
- Drives the 2-bit ALUOp that the ALU control unit combines with the funct field to select the ALU operation.
- Stretches memory states until the memory reports ready.

Parameters:
- STATE_W, 4, width of the state register / state debug output.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset. Only one clock (clk). Reset is asynchronous and active-high.
- opcode  in  6  instruction[31:26] from the instruction register.
- mem_ready  in  1  memory access complete this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero.
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  1 = write-back data from MDR.
- RegDst  out  1  1 = rd, 0 = rt.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- ALUOp  out  2  00 = R-type (funct decode), 01 = subtract, 10 = add, 11 = never driven.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on unknown opcode.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- retired  out  CNT_W  count of completed instructions.
- state  out  STATE_W  current state encoding.

Behaviour:
- Reset:
  - While rst=1: state=FETCH(0), retired=0, and every control output is 0, including ALUOp=00 and ALUSrcB=00.
  - The first FETCH activity begins on the first cycle after rst deasserts.
  - rst asserted mid-instruction aborts it immediately; no partial RegWrite or MemWrite occurs after the edge.
- Output style:
  - All outputs are Moore (decoded from state).
  - Exception: IRWrite/PCWrite in FETCH and completion in the memory states are gated by mem_ready.
  - Any output not listed for a state is 0.
- Opcodes: R-type 6'h00, lw 6'h23, sw 6'h2B, beq 6'h04, j 6'h02, addi 6'h08.
- States and outputs:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=10, PCSource=00, IRWrite=PCWrite=mem_ready. Stay until mem_ready=1, then go to DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=10.
    - lw/sw → MEM_ADDR; R-type → EXEC_R; beq → BRANCH; j → JUMP; addi → EXEC_I.
    - Any other opcode: illegal_op=1 this cycle → FETCH, retired unchanged.
  - MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=10. lw → MEM_READ, sw → MEM_WRITE.
  - MEM_READ(3): MemRead=1, IorD=1. Hold until mem_ready, then → WB_LOAD.
  - WB_LOAD(4): RegWrite=1, MemtoReg=1, RegDst=0 → FETCH.
  - MEM_WRITE(5): MemWrite=1, IorD=1. Hold until mem_ready, then → FETCH.
  - EXEC_R(6): ALUSrcA=1, ALUSrcB=00, ALUOp=00 → WB_R.
  - WB_R(7): RegWrite=1, RegDst=1 → FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 → FETCH.
  - JUMP(9): PCWrite=1, PCSource=10 → FETCH.
  - EXEC_I(10): ALUSrcA=1, ALUSrcB=10, ALUOp=10 → WB_I.
  - WB_I(11): RegWrite=1, RegDst=0 → FETCH.
  - Encodings 12-15: outputs 0, next state FETCH.
- instr_done and retired:
  - instr_done=1 in WB_LOAD, WB_R, BRANCH, JUMP, WB_I, and in MEM_WRITE when mem_ready=1.
  - retired increments on the clock edge ending each instr_done cycle and wraps from 2^CNT_W-1 to 0.
- Latency:
  - With mem_ready held at 1: lw 5 cycles; sw, R-type and addi 4; beq and j 3; illegal 2.
  - Each cycle mem_ready=0 in FETCH/MEM_READ/MEM_WRITE adds exactly one cycle.
- opcode is sampled only in DECODE and MEM_ADDR. It must be stable from the cycle after IRWrite.

Test Plan:
- Reset: rst=1 mid-MEM_WRITE → asynchronously state=0 and MemWrite=0 before the next edge; retired=0; after release, FETCH shows MemRead=1, ALUOp=10.
- R-type: opcode=6'h00, mem_ready=1 → states 0,1,6,7,0. ALUOp=00 in state 6; RegWrite=1, RegDst=1 in state 7; retired=1 after 4 cycles.
- lw with wait: opcode=6'h23, mem_ready low 2 cycles in MEM_READ → states 0,1,2,3,3,3,4,0; MemtoReg=1 and RegWrite=1 only in state 4.
- beq then j: opcode=6'h04 → BRANCH with ALUOp=01, PCWriteCond=1, PCSource=01. Then opcode=6'h02 → JUMP with PCWrite=1, PCSource=10; retired +2.
- Illegal opcode: opcode=6'h3F → illegal_op=1 for one cycle in DECODE, back to FETCH, retired unchanged, no RegWrite/MemWrite.
- Fetch stall and wrap: mem_ready=0 for 3 cycles in FETCH → IRWrite=PCWrite=0 throughout. Separately, preload retired=16'hFFFF and complete an addi → retired=0.
